rename_map_table: RTL and testbench

// Parametrised front-end rename table, successor to the dual-issue f_rat. Each cycle it renames up to ISSUE_W

---
 rtl/rename_map_table.sv | 201 ++++++++++++++++++++
 tb/tb_rename_map_table.sv | 292 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/rename_map_table.sv
// Front-end register rename table with in-group dependency bypass,
// retire clearing and an in-order queue of branch checkpoints that the
// table can be restored from on a mispredict.
module rename_map_table #(
  parameter  int ISSUE_W   = 2,
  parameter  int RET_W     = 2,
  parameter  int NUM_AREGS = 32,
  parameter  int ROB_DEPTH = 64,
  parameter  int NUM_CKPT  = 4,
  localparam int AREG_W    = $clog2(NUM_AREGS),
  localparam int ROBID_W   = $clog2(ROB_DEPTH),
  localparam int CKPT_W    = $clog2(NUM_CKPT)
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [ISSUE_W-1:0]                   id_val,
  input  logic [ISSUE_W-1:0]                   id_rd_val,
  input  logic [ISSUE_W-1:0][AREG_W-1:0]       id_rd,
  input  logic [ISSUE_W-1:0][AREG_W-1:0]       id_rs1,
  input  logic [ISSUE_W-1:0][AREG_W-1:0]       id_rs2,
  input  logic [ISSUE_W-1:0]                   id_ckpt,
  input  logic [ROBID_W-1:0]                   rob_is_ptr,
  output logic                                 id_ready,
  input  logic [RET_W-1:0]                     ret_val,
  input  logic [RET_W-1:0][AREG_W-1:0]         ret_rd,
  input  logic [RET_W-1:0][ROBID_W-1:0]        ret_robid,
  input  logic                                 ckpt_pop,
  input  logic                                 flush_val,
  input  logic [CKPT_W-1:0]                    flush_ckpt_id,
  input  logic                                 flush_all,
  output logic [ISSUE_W-1:0]                   rn_val,
  output logic [ISSUE_W-1:0][1:0][ROBID_W-1:0] rn_src_tag,
  output logic [ISSUE_W-1:0][1:0]              rn_src_rob,
  output logic [ISSUE_W-1:0][ROBID_W-1:0]      rn_robid,
  output logic [CKPT_W-1:0]                    rn_ckpt_id
);

  localparam logic [CKPT_W:0] CKPT_FULL = (CKPT_W+1)'(NUM_CKPT);

  // live table: in_rob flags are control (reset), robids are data
  logic [NUM_AREGS-1:0]                           tab_in_rob;
  logic [NUM_AREGS-1:0][ROBID_W-1:0]              tab_robid;
  // checkpoint copies of the table
  logic [NUM_CKPT-1:0][NUM_AREGS-1:0]             ck_in_rob;
  logic [NUM_CKPT-1:0][NUM_AREGS-1:0][ROBID_W-1:0] ck_robid;
  // checkpoint queue pointers
  logic [CKPT_W-1:0] head, tail;
  logic [CKPT_W:0]   cnt;

  logic                                  has_br, alloc, pop_ok;
  logic [CKPT_W-1:0]                     flush_dist;
  logic [ISSUE_W-1:0][1:0][AREG_W-1:0]   src_areg;
  logic [ISSUE_W-1:0][1:0][ROBID_W-1:0]  src_tag;
  logic [ISSUE_W-1:0][1:0]               src_rob;

  logic [NUM_AREGS-1:0]                            clr_in_rob, wr_in_rob, snap_in_rob;
  logic [NUM_AREGS-1:0][ROBID_W-1:0]               wr_robid, snap_robid;
  logic [NUM_CKPT-1:0][NUM_AREGS-1:0]              ck_clr_in_rob, ck_in_rob_nx;
  logic [NUM_CKPT-1:0][NUM_AREGS-1:0][ROBID_W-1:0] ck_robid_nx;

  logic [ISSUE_W-1:0]                    rn_val_nx;
  logic [ISSUE_W-1:0][1:0][ROBID_W-1:0]  rn_src_tag_nx;
  logic [ISSUE_W-1:0][1:0]               rn_src_rob_nx;
  logic [ISSUE_W-1:0][ROBID_W-1:0]       rn_robid_nx;
  logic [CKPT_W-1:0]                     rn_ckpt_id_nx;

  assign has_br     = |(id_val & id_ckpt);
  assign id_ready   = ~flush_val & ~flush_all & ((cnt < CKPT_FULL) | ~has_br);
  assign alloc      = id_ready & has_br;
  assign pop_ok     = ckpt_pop & (cnt != '0);
  assign flush_dist = flush_ckpt_id - head;

  // source lookup: table read, then youngest older in-group writer overrides; x0 forced to zero
  always_comb begin
    src_areg = '0;
    src_rob  = '0;
    src_tag  = '0;
    for (int i = 0; i < ISSUE_W; i++) begin
      src_areg[i][0] = id_rs1[i];
      src_areg[i][1] = id_rs2[i];
      for (int s = 0; s < 2; s++) begin
        src_rob[i][s] = tab_in_rob[src_areg[i][s]];
        src_tag[i][s] = tab_in_rob[src_areg[i][s]] ? tab_robid[src_areg[i][s]]
                                                     : ROBID_W'(src_areg[i][s]);
        for (int j = 0; j < i; j++) begin
          if (id_val[j] && id_rd_val[j] && (id_rd[j] == src_areg[i][s])) begin
            src_rob[i][s] = 1'b1;
            src_tag[i][s] = rob_is_ptr + ROBID_W'(j);
          end
        end
        if (src_areg[i][s] == '0) begin
          src_rob[i][s] = 1'b0;
          src_tag[i][s] = '0;
        end
      end
    end
  end

  // next table/checkpoint contents: retire clears first, then rename writes in slot order
  always_comb begin
    clr_in_rob = tab_in_rob;
    for (int p = 0; p < RET_W; p++) begin
      if (ret_val[p] && tab_in_rob[ret_rd[p]] && (tab_robid[ret_rd[p]] == ret_robid[p]))
        clr_in_rob[ret_rd[p]] = 1'b0;
    end
    ck_clr_in_rob = ck_in_rob;
    for (int c = 0; c < NUM_CKPT; c++) begin
      for (int p = 0; p < RET_W; p++) begin
        if (ret_val[p] && ck_in_rob[c][ret_rd[p]] && (ck_robid[c][ret_rd[p]] == ret_robid[p]))
          ck_clr_in_rob[c][ret_rd[p]] = 1'b0;
      end
    end
    wr_in_rob   = clr_in_rob;
    wr_robid    = tab_robid;
    snap_in_rob = clr_in_rob;
    snap_robid  = tab_robid;
    for (int i = 0; i < ISSUE_W; i++) begin
      if (id_ready && id_val[i] && id_rd_val[i] && (id_rd[i] != '0)) begin
        wr_in_rob[id_rd[i]] = 1'b1;
        wr_robid[id_rd[i]]  = rob_is_ptr + ROBID_W'(i);
      end
      // the branch's snapshot includes its own slot and all older ones
      if (id_ready && id_val[i] && id_ckpt[i]) begin
        snap_in_rob = wr_in_rob;
        snap_robid  = wr_robid;
      end
    end
    ck_in_rob_nx = ck_clr_in_rob;
    ck_robid_nx  = ck_robid;
    if (alloc) begin
      ck_in_rob_nx[tail] = snap_in_rob;
      ck_robid_nx[tail]  = snap_robid;
    end
  end

  // renamed group for the issue stage
  always_comb begin
    rn_val_nx     = '0;
    rn_src_tag_nx = '0;
    rn_src_rob_nx = '0;
    rn_robid_nx   = '0;
    rn_ckpt_id_nx = '0;
    if (id_ready) begin
      for (int i = 0; i < ISSUE_W; i++) begin
        if (id_val[i]) begin
          rn_val_nx[i]     = 1'b1;
          rn_src_tag_nx[i] = src_tag[i];
          rn_src_rob_nx[i] = src_rob[i];
          rn_robid_nx[i]   = rob_is_ptr + ROBID_W'(i);
        end
      end
    end
    if (alloc)
      rn_ckpt_id_nx = tail;
  end

  // table in_rob flags and checkpoint queue pointers
  always_ff @(posedge clk) begin
    if (rst || flush_all) begin
      tab_in_rob <= '0;
      head       <= '0;
      tail       <= '0;
      cnt        <= '0;
    end else if (flush_val) begin
      tab_in_rob <= ck_clr_in_rob[flush_ckpt_id];
      head       <= head + CKPT_W'(pop_ok);
      tail       <= flush_ckpt_id + CKPT_W'(1);
      cnt        <= (CKPT_W+1)'(flush_dist) + (CKPT_W+1)'(1) - (CKPT_W+1)'(pop_ok);
    end else begin
      tab_in_rob <= wr_in_rob;
      head       <= head + CKPT_W'(pop_ok);
      tail       <= tail + CKPT_W'(alloc);
      cnt        <= cnt + (CKPT_W+1)'(alloc) - (CKPT_W+1)'(pop_ok);
    end
  end

  // table robids and checkpoint copies (no reset: qualified by in_rob and queue pointers)
  always_ff @(posedge clk) begin
    tab_robid <= flush_val ? ck_robid[flush_ckpt_id] : wr_robid;
    ck_in_rob <= ck_in_rob_nx;
    ck_robid  <= ck_robid_nx;
  end

  // output stage (_p1): registered renamed group, cleared on reset and full flush
  always_ff @(posedge clk) begin
    if (rst || flush_all) begin
      rn_val     <= '0;
      rn_src_tag <= '0;
      rn_src_rob <= '0;
      rn_robid   <= '0;
      rn_ckpt_id <= '0;
    end else begin
      rn_val     <= rn_val_nx;
      rn_src_tag <= rn_src_tag_nx;
      rn_src_rob <= rn_src_rob_nx;
      rn_robid   <= rn_robid_nx;
      rn_ckpt_id <= rn_ckpt_id_nx;
    end
  end

endmodule

// File: tb/tb_rename_map_table.sv
// Scoreboard bench for rename_map_table: a queue/array reference model
// predicts each accepted group; a monitor compares registered outputs.
module tb_rename_map_table;
  localparam int IW = 2, RW = 2, NA = 32, NC = 4, AW = 5, BW = 6, CW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic                       rst;
  logic [IW-1:0]              id_val, id_rd_val, id_ckpt;
  logic [IW-1:0][AW-1:0]      id_rd, id_rs1, id_rs2;
  logic [BW-1:0]              rob_is_ptr;
  logic                       id_ready;
  logic [RW-1:0]              ret_val;
  logic [RW-1:0][AW-1:0]      ret_rd;
  logic [RW-1:0][BW-1:0]      ret_robid;
  logic                       ckpt_pop, flush_val, flush_all;
  logic [CW-1:0]              flush_ckpt_id;
  logic [IW-1:0]              rn_val;
  logic [IW-1:0][1:0][BW-1:0] rn_src_tag;
  logic [IW-1:0][1:0]         rn_src_rob;
  logic [IW-1:0][BW-1:0]      rn_robid;
  logic [CW-1:0]              rn_ckpt_id;

  rename_map_table dut (
    .clk(clk), .rst(rst), .id_val(id_val), .id_rd_val(id_rd_val), .id_rd(id_rd),
    .id_rs1(id_rs1), .id_rs2(id_rs2), .id_ckpt(id_ckpt), .rob_is_ptr(rob_is_ptr),
    .id_ready(id_ready), .ret_val(ret_val), .ret_rd(ret_rd), .ret_robid(ret_robid),
    .ckpt_pop(ckpt_pop), .flush_val(flush_val), .flush_ckpt_id(flush_ckpt_id),
    .flush_all(flush_all), .rn_val(rn_val), .rn_src_tag(rn_src_tag),
    .rn_src_rob(rn_src_rob), .rn_robid(rn_robid), .rn_ckpt_id(rn_ckpt_id)
  );

  typedef struct packed {
    logic [IW-1:0]              val;
    logic [IW-1:0][1:0][BW-1:0] tag;
    logic [IW-1:0][1:0]         rob;
    logic [IW-1:0][BW-1:0]      robid;
    logic [CW-1:0]              ckid;
  } exp_t;

  typedef struct packed {
    logic [CW-1:0]             id;
    logic [NA-1:0]             inrob;
    logic [NA-1:0][BW-1:0]     rob;
  } ck_t;

  int   n_cmp = 0;
  int   n_bad = 0;
  exp_t sbq[$];

  // reference model state: architectural map and ordered checkpoint list
  logic [NA-1:0]         m_inrob = '0;
  logic [NA-1:0][BW-1:0] m_rob   = '0;
  ck_t                   ckq[$];
  int                    m_tail  = 0;

  task automatic idle();
    id_val = '0; id_rd_val = '0; id_ckpt = '0;
    id_rd = '0; id_rs1 = '0; id_rs2 = '0;
    ret_val = '0; ret_rd = '0; ret_robid = '0;
    ckpt_pop = 1'b0; flush_val = 1'b0; flush_all = 1'b0; flush_ckpt_id = '0;
  endtask

  task automatic set_slot(input int i, input logic rdv, input int rd, input int rs1,
                          input int rs2, input logic ck);
    id_val[i] = 1'b1; id_rd_val[i] = rdv; id_rd[i] = AW'(rd);
    id_rs1[i] = AW'(rs1); id_rs2[i] = AW'(rs2); id_ckpt[i] = ck;
  endtask

  // predict this cycle from the current inputs, then advance the model
  task automatic model_step();
    logic          br, rdy, hit;
    logic [AW-1:0] rs;
    logic [NA-1:0] clr;
    logic [NA-1:0]         snap_in;
    logic [NA-1:0][BW-1:0] snap_rob;
    exp_t e;
    ck_t  c;
    int   k;
    br  = |(id_val & id_ckpt);
    rdy = !flush_val && !flush_all && (ckq.size() < NC || !br);
    n_cmp++;
    if (id_ready !== rdy) begin
      n_bad++;
      $display("FAIL id_ready got=%b exp=%b t=%0t", id_ready, rdy, $time);
    end
    if (rdy && id_val != '0) begin
      e = '0;
      for (int i = 0; i < IW; i++) begin
        if (id_val[i]) begin
          e.val[i]   = 1'b1;
          e.robid[i] = BW'(rob_is_ptr + i);
          for (int s = 0; s < 2; s++) begin
            rs  = (s == 0) ? id_rs1[i] : id_rs2[i];
            hit = 1'b0;
            if (rs != 0) begin
              for (int j = i - 1; j >= 0; j--) begin
                if (!hit && id_rd_val[j] && id_rd[j] == rs) begin
                  hit = 1'b1; e.rob[i][s] = 1'b1; e.tag[i][s] = BW'(rob_is_ptr + j);
                end
              end
              if (!hit) begin
                e.rob[i][s] = m_inrob[rs];
                e.tag[i][s] = m_inrob[rs] ? m_rob[rs] : BW'(rs);
              end
            end
          end
        end
      end
      if (br) e.ckid = CW'(m_tail);
      sbq.push_back(e);
    end
    // retirement clears a mapping only if it still names the retiring ROB id
    clr = m_inrob;
    for (int p = 0; p < RW; p++)
      if (ret_val[p] && m_inrob[ret_rd[p]] && m_rob[ret_rd[p]] == ret_robid[p]) clr[ret_rd[p]] = 1'b0;
    m_inrob = clr;
    for (int q = 0; q < ckq.size(); q++) begin
      c = ckq[q];
      clr = c.inrob;
      for (int p = 0; p < RW; p++)
        if (ret_val[p] && c.inrob[ret_rd[p]] && c.rob[ret_rd[p]] == ret_robid[p]) clr[ret_rd[p]] = 1'b0;
      c.inrob = clr;
      ckq[q] = c;
    end
    if (flush_all) begin
      m_inrob = '0; ckq.delete(); m_tail = 0;
    end else if (flush_val) begin
      k = -1;
      for (int q = 0; q < ckq.size(); q++) if (ckq[q].id == flush_ckpt_id) k = q;
      if (k >= 0) begin
        m_inrob = ckq[k].inrob; m_rob = ckq[k].rob;
        while (ckq.size() > k + 1) void'(ckq.pop_back());
      end
      m_tail = (int'(flush_ckpt_id) + 1) % NC;
      if (ckpt_pop && ckq.size() > 0) void'(ckq.pop_front());
    end else begin
      if (ckpt_pop && ckq.size() > 0) void'(ckq.pop_front());
      if (rdy) begin
        snap_in = m_inrob; snap_rob = m_rob;
        for (int i = 0; i < IW; i++) begin
          if (id_val[i] && id_rd_val[i] && id_rd[i] != 0) begin
            m_inrob[id_rd[i]] = 1'b1; m_rob[id_rd[i]] = BW'(rob_is_ptr + i);
          end
          if (id_val[i] && id_ckpt[i]) begin snap_in = m_inrob; snap_rob = m_rob; end
        end
        if (br) begin
          c.id = CW'(m_tail); c.inrob = snap_in; c.rob = snap_rob;
          ckq.push_back(c);
          m_tail = (m_tail + 1) % NC;
        end
      end
    end
  endtask

  // inputs are set at a negedge; the model looks at them once they settle
  task automatic step();
    #1;
    model_step();
    @(negedge clk);
  endtask

  task automatic check_zero(input string name);
    n_cmp++;
    if ({rn_val, rn_src_tag, rn_src_rob, rn_robid, rn_ckpt_id} !== '0) begin
      n_bad++;
      $display("FAIL %s outputs got=%h exp=0", name,
               {rn_val, rn_src_tag, rn_src_rob, rn_robid, rn_ckpt_id});
    end
  endtask

  // monitor: one cycle after acceptance the DUT must present the predicted group
  always @(posedge clk) begin
    exp_t e, g;
    #1;
    if (!rst) begin
      g = {rn_val, rn_src_tag, rn_src_rob, rn_robid, rn_ckpt_id};
      if (rn_val != '0) begin
        n_cmp++;
        if (sbq.size() == 0) begin
          n_bad++;
          $display("FAIL unexpected_group got=%h exp=none t=%0t", g, $time);
        end else begin
          e = sbq.pop_front();
          if (g !== e) begin
            n_bad++;
            $display("FAIL rn_group got=%h exp=%h t=%0t", g, e, $time);
          end
        end
      end else if (sbq.size() > 0) begin
        e = sbq.pop_front();
        n_cmp++; n_bad++;
        $display("FAIL missing_group got=%h exp=%h t=%0t", g, e, $time);
      end
    end
  end

  initial begin
    int v, r, sl;
    idle();
    rob_is_ptr = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_zero("reset");
    rst = 1'b0;

    // basic lookup and dependent rename
    idle(); set_slot(0, 0, 0, 5, 0, 0); step();
    idle(); rob_is_ptr = 6'd7; set_slot(0, 1, 3, 0, 0, 0); step();
    idle(); set_slot(0, 0, 0, 3, 0, 0); step();
    // in-group bypass, same-rd collision and ROB id wrap
    idle(); rob_is_ptr = 6'd63; set_slot(0, 1, 4, 0, 0, 0); set_slot(1, 1, 4, 0, 4, 0); step();
    idle(); set_slot(0, 0, 0, 4, 0, 0); step();
    // retire with stale / matching robid, and retire racing a rename
    idle(); rob_is_ptr = 6'd9; set_slot(0, 1, 3, 0, 0, 0); step();
    idle(); ret_val = 2'b01; ret_rd[0] = 5'd3; ret_robid[0] = 6'd8; set_slot(0, 0, 0, 3, 0, 0); step();
    idle(); ret_val = 2'b01; ret_rd[0] = 5'd3; ret_robid[0] = 6'd9; step();
    idle(); set_slot(0, 0, 0, 3, 0, 0); step();
    idle(); rob_is_ptr = 6'd10; set_slot(0, 1, 3, 0, 0, 0); step();
    idle(); rob_is_ptr = 6'd11; set_slot(0, 1, 3, 0, 0, 0);
    ret_val = 2'b01; ret_rd[0] = 5'd3; ret_robid[0] = 6'd10; step();
    idle(); set_slot(0, 0, 0, 3, 3, 0); step();
    // fill the checkpoint queue, then stall only branch groups
    for (int i = 0; i < NC; i++) begin
      idle(); rob_is_ptr = BW'(20 + i); set_slot(0, 1, 8 + i, 0, 0, 1); step();
    end
    idle(); set_slot(0, 0, 0, 8, 0, 1); step();
    idle(); set_slot(0, 0, 0, 9, 0, 0); set_slot(1, 0, 0, 10, 0, 0); step();
    idle(); ckpt_pop = 1'b1; set_slot(0, 0, 0, 11, 0, 1); step();
    // restore from a mid-queue checkpoint
    idle(); flush_all = 1'b1; step();
    check_zero("flush_all");
    idle(); set_slot(0, 0, 0, 0, 0, 1); step();
    idle(); rob_is_ptr = 6'd12; set_slot(0, 1, 2, 0, 0, 1); step();
    idle(); rob_is_ptr = 6'd20; set_slot(0, 1, 2, 0, 0, 1); step();
    idle(); set_slot(0, 0, 0, 0, 0, 1); step();
    idle(); flush_val = 1'b1; flush_ckpt_id = 2'd1; step();
    idle(); set_slot(0, 0, 0, 2, 0, 0); step();
    idle(); set_slot(0, 0, 0, 0, 0, 1); step();
    idle(); ret_val = 2'b10; ret_rd[1] = 5'd2; ret_robid[1] = 6'd12; step();
    idle(); flush_val = 1'b1; flush_ckpt_id = 2'd1; step();
    idle(); set_slot(0, 0, 0, 2, 0, 0); set_slot(1, 1, 2, 2, 0, 0); step();
    idle(); rob_is_ptr = 6'd30; set_slot(0, 1, 6, 0, 0, 0); flush_all = 1'b1; step();
    check_zero("flush_all_group");
    idle(); set_slot(0, 0, 0, 6, 2, 0); step();

    // randomized traffic
    for (int n = 0; n < 3000; n++) begin
      idle();
      v = $urandom_range(0, 3);
      id_val = (v == 0) ? 2'b00 : (v == 1) ? 2'b01 : 2'b11;
      for (int i = 0; i < IW; i++) begin
        if (id_val[i]) begin
          id_rd_val[i] = 1'($urandom);
          id_rd[i]     = AW'($urandom_range(0, 7));
          id_rs1[i]    = AW'($urandom_range(0, 7));
          id_rs2[i]    = AW'($urandom_range(0, 7));
        end
      end
      if (id_val != 0 && $urandom_range(0, 3) == 0) begin
        sl = (id_val == 2'b11) ? $urandom_range(0, 1) : 0;
        id_ckpt[sl] = 1'b1;
      end
      rob_is_ptr = BW'($urandom);
      for (int p = 0; p < RW; p++) begin
        if ($urandom_range(0, 1) == 1) begin
          r = $urandom_range(0, 7);
          ret_val[p] = 1'b1; ret_rd[p] = AW'(r);
          ret_robid[p] = ($urandom_range(0, 3) != 0) ? m_rob[r] : BW'($urandom);
        end
      end
      ckpt_pop = ($urandom_range(0, 3) == 0);
      if (ckq.size() > 0 && $urandom_range(0, 19) == 0) begin
        flush_val = 1'b1;
        flush_ckpt_id = ckq[$urandom_range(0, ckq.size() - 1)].id;
      end
      flush_all = ($urandom_range(0, 149) == 0);
      step();
    end

    idle(); step(); step();
    n_cmp++;
    if (sbq.size() != 0) begin
      n_bad++;
      $display("FAIL drain got=%0d pending exp=0", sbq.size());
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
